// File: rtl/timer_control.sv
// Control FSM for the 20-second game countdown. It paces seconds with an internal
// divider and issues ld_wait/ld_set/ld_one/ld_ten commands to the timer datapath.
module timer_control #(
    parameter int CLKS_PER_SEC = 50_000_000,
    parameter int CW           = $clog2(CLKS_PER_SEC)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       pause,
    input  logic       changeTen,
    input  logic       done,
    output logic       ld_wait,
    output logic       ld_set,
    output logic       ld_one,
    output logic       ld_ten,
    output logic       sec_tick,
    output logic       running,
    output logic       time_up,
    output logic [2:0] dbg_state
);

    typedef enum logic [2:0] {
        S_WAIT  = 3'd0,
        S_SET   = 3'd1,
        S_COUNT = 3'd2,
        S_ONE   = 3'd3,
        S_CHK1  = 3'd4,
        S_TEN   = 3'd5,
        S_CHK2  = 3'd6,
        S_DONE  = 3'd7
    } state_t;

    localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_SEC - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          cnt_run;
    logic          cnt_wrap;
    logic          tick;

    // The divider keeps counting through S_ONE..S_CHK2 so the second period stays exact.
    always_comb begin
        cnt_run = 1'b0;
        case (state_q)
            S_COUNT, S_ONE, S_CHK1, S_TEN, S_CHK2: cnt_run = 1'b1;
            default:                               cnt_run = 1'b0;
        endcase
    end

    assign cnt_wrap = (cnt_q == CNT_MAX);
    assign tick     = cnt_wrap & ~pause;

    always_comb begin
        cnt_d = cnt_q;
        if (!cnt_run) begin
            cnt_d = '0;
        end else if (!pause) begin
            cnt_d = cnt_wrap ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_WAIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ld_wait = 1'b0;
        ld_set  = 1'b0;
        ld_one  = 1'b0;
        ld_ten  = 1'b0;
        running = 1'b0;
        time_up = 1'b0;
        case (state_q)
            S_WAIT: begin
                ld_wait = 1'b1;
                if (start) state_d = S_SET;
            end
            S_SET: begin
                ld_set  = 1'b1;
                running = 1'b1;
                state_d = S_COUNT;
            end
            S_COUNT: begin
                running = 1'b1;
                if (tick) state_d = S_ONE;
            end
            S_ONE: begin
                ld_one  = 1'b1;
                running = 1'b1;
                state_d = S_CHK1;
            end
            S_CHK1: begin
                // changeTen was refreshed by the datapath on the S_ONE edge.
                running = 1'b1;
                state_d = changeTen ? S_TEN : S_COUNT;
            end
            S_TEN: begin
                ld_ten  = 1'b1;
                running = 1'b1;
                state_d = S_CHK2;
            end
            S_CHK2: begin
                running = 1'b1;
                state_d = done ? S_DONE : S_COUNT;
            end
            S_DONE: begin
                time_up = 1'b1;
                if (start) state_d = S_SET;
            end
            default: state_d = S_WAIT;
        endcase
    end

    assign sec_tick  = tick & (state_q == S_COUNT);
    assign dbg_state = state_q;

    a_ld_exclusive: assert property (@(posedge clk) disable iff (reset)
        $onehot0({ld_set, ld_one, ld_ten}));
    a_tick_in_count: assert property (@(posedge clk) disable iff (reset)
        tick |-> (state_q == S_COUNT));

endmodule

// File: tb/tb_timer_control.sv
// Bench for timer_control: a behavioural digit datapath closes the loop and an
// event-scheduling reference model predicts every output cycle by cycle.
module tb_timer_control;

    localparam int CPS = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       changeTen = 1'b0;
    logic       done = 1'b0;
    logic       ld_wait, ld_set, ld_one, ld_ten, sec_tick, running, time_up;
    logic [2:0] dbg_state;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    timer_control #(.CLKS_PER_SEC(CPS)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .pause    (pause),
        .changeTen(changeTen),
        .done     (done),
        .ld_wait  (ld_wait),
        .ld_set   (ld_set),
        .ld_one   (ld_one),
        .ld_ten   (ld_ten),
        .sec_tick (sec_tick),
        .running  (running),
        .time_up  (time_up),
        .dbg_state(dbg_state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Two-digit timer datapath; not touched by reset, re-preset only by ld_wait/ld_set.
    int dp_tens = 2;
    int dp_ones = 0;
    int disp;
    assign disp = dp_tens * 10 + dp_ones;

    always @(posedge clk) begin
        if (ld_wait || ld_set) begin
            dp_tens   <= 2;
            dp_ones   <= 0;
            changeTen <= 1'b0;
            done      <= 1'b0;
        end else if (ld_one) begin
            if (dp_ones == 0) begin
                changeTen <= 1'b1;
                if (dp_tens != 0) dp_ones <= 9;
            end else begin
                dp_ones   <= dp_ones - 1;
                changeTen <= 1'b0;
            end
        end else if (ld_ten) begin
            changeTen <= 1'b0;
            if (dp_tens == 0) done <= 1'b1;
            else dp_tens <= dp_tens - 1;
        end
    end

    // Reference model: phase 0 idle, 1 loading, 2 counting, 3 ended. Pulses are
    // scheduled as absolute cycle numbers from the seconds elapsed in the round.
    int m_phase = 0;
    int m_acc = 0;
    int m_secs = 0;
    int m_cyc = 0;
    int one_at = -1;
    int ten_at = -1;
    int end_at = -1;

    always @(posedge clk or posedge reset) begin
        int v;
        if (reset) begin
            m_phase = 0; m_acc = 0; m_secs = 0; m_cyc = 0;
            one_at = -1; ten_at = -1; end_at = -1;
        end else begin
            case (m_phase)
                0: if (start) m_phase = 1;
                1: begin
                    m_phase = 2; m_acc = 0; m_secs = 0;
                    one_at = -1; ten_at = -1; end_at = -1;
                end
                2: begin
                    if (m_acc == CPS - 1 && !pause) begin
                        v = 20 - m_secs;
                        m_secs++;
                        one_at = m_cyc + 1;
                        if (v % 10 == 0) ten_at = m_cyc + 3;
                        if (v == 0) end_at = m_cyc + 5;
                    end
                    if (!pause) m_acc = (m_acc + 1) % CPS;
                    if (m_cyc + 1 == end_at) m_phase = 3;
                end
                default: if (start) m_phase = 1;
            endcase
            m_cyc++;
        end
    end

    // Per-cycle scoreboard plus pulse counters for the round-level totals.
    int n_one = 0;
    int n_ten = 0;

    always @(negedge clk) begin
        logic       exp_tick;
        logic [6:0] exp_v;
        exp_tick = (m_phase == 2) && (m_acc == CPS - 1) && !pause;
        exp_v = {m_phase == 0, m_phase == 1, m_cyc == one_at, m_cyc == ten_at,
                 exp_tick, (m_phase == 1) || (m_phase == 2), m_phase == 3};
        check("outs", 32'({ld_wait, ld_set, ld_one, ld_ten, sec_tick, running, time_up}),
              32'(exp_v));
        if (exp_tick) check("disp_at_tick", 32'(disp), 32'(20 - m_secs));
        if (m_phase == 3) begin
            check("done_flag", 32'(done), 32'd1);
            check("disp_end", 32'(disp), 32'd0);
        end
        if (ld_set) begin
            n_one = 0;
            n_ten = 0;
        end
        if (ld_one) n_one++;
        if (ld_ten) n_ten++;
    end

    task automatic drive(input logic st, input logic ps);
        start = st;
        pause = ps;
        @(posedge clk);
        #1;
    endtask

    // Random pause and (optionally) random start while counting, until the display
    // reaches target (target < 0 means until the round ends) or the budget runs out.
    task automatic rnd_run(input int target, input int budget, input bit starts);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (target >= 0 ? (m_phase == 2 && disp == target) : (m_phase == 3)) begin
                hit = 1'b1;
                break;
            end
            drive(starts && m_phase == 2 && $urandom_range(0, 4) == 0,
                  $urandom_range(0, 6) == 0);
        end
        check("wait_budget", 32'(hit), 32'd1);
        start = 1'b0;
        pause = 1'b0;
    endtask

    initial begin
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Idle: pause and elapsed time must not matter.
        for (int i = 0; i < 15; i++) drive(1'b0, $urandom_range(0, 1) == 1);
        check("idle_disp", 32'(disp), 32'd20);
        check("idle_wait", 32'(ld_wait), 32'd1);

        // Full round with random pauses, stray starts, and a long pause at 15.
        drive(1'b1, 1'b0);
        drive(1'b0, 1'b0);
        rnd_run(15, 600, 1'b1);
        repeat (30) drive(1'b0, 1'b1);
        check("pause_disp", 32'(disp), 32'd15);
        rnd_run(-1, 800, 1'b1);
        check("ones_per_round", 32'(n_one), 32'd21);
        check("tens_per_round", 32'(n_ten), 32'd3);
        for (int i = 0; i < 20; i++) drive(1'b0, $urandom_range(0, 1) == 1);
        check("hold_disp", 32'(disp), 32'd0);

        // Restart from the ended state, then reset asynchronously at 07.
        drive(1'b1, 1'b0);
        drive(1'b0, 1'b0);
        check("restart_disp", 32'(disp), 32'd20);
        rnd_run(7, 800, 1'b0);
        @(negedge clk);
        #2 reset = 1'b1;
        #1 check("async_rst_outs",
                 32'({ld_wait, ld_set, ld_one, ld_ten, sec_tick, running, time_up}),
                 32'(7'b1000000));
        #1 reset = 1'b0;
        @(posedge clk);
        #1 check("rst_disp", 32'(disp), 32'd20);

        // Start held high throughout a stretch of counting must not reload.
        drive(1'b1, 1'b0);
        drive(1'b0, 1'b0);
        for (int i = 0; i < 60; i++) drive(1'b1, $urandom_range(0, 9) == 0);
        check("start_ignored", 32'(n_one), 32'(m_secs));
        rnd_run(-1, 800, 1'b1);
        check("ones_round2", 32'(n_one), 32'd21);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, want finish before 1ms");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/timer_control.md
# timer_control

Control FSM for the arcade game's 20-second countdown: the issuing end of the timer datapath's ld_wait/ld_set/ld_one/ld_ten interface. It paces the countdown with an internal 1 Hz divider, commands one-digit and ten-digit decrements, and reacts to the datapath's changeTen/done feedback. It sits between the game controller (start/pause/time_up) and the timer datapath, whose digit outputs feed the HEX display.

## Interface

- CLKS_PER_SEC, default 50_000_000: clock cycles per game second; must be ≥ 8.
- CW, default $clog2(CLKS_PER_SEC): divider counter width.

- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; one clock, no other clock domains.
- start  in  1  level; begin or restart a round.
- pause  in  1  level; freezes the countdown while high.
- changeTen  in  1  datapath: ones digit has wrapped, ten decrement needed.
- done  in  1  datapath: countdown exhausted.
- ld_wait  out  1  datapath: idle preset (00 → 20).
- ld_set  out  1  datapath: load 20 for a new round.
- ld_one  out  1  datapath: decrement ones digit.
- ld_ten  out  1  datapath: decrement tens digit or flag done.
- sec_tick  out  1  one-cycle pulse per elapsed game second.
- running  out  1  high while a round is counting.
- time_up  out  1  high once the round has ended.

## Operation

- Moore FSM; all ld_*, running and time_up decode from state only.
- S_WAIT: ld_wait=1. start=1 → S_SET.
- S_SET, 1 cycle: ld_set=1 → S_COUNT.
- S_COUNT: wait for the divider tick. tick and pause=0 → S_ONE.
- S_ONE, 1 cycle: ld_one=1 → S_CHK1.
- S_CHK1, 1 cycle: samples changeTen, which the datapath updated on the S_ONE edge. changeTen=1 → S_TEN; otherwise → S_COUNT.
- S_TEN, 1 cycle: ld_ten=1 → S_CHK2.
- S_CHK2, 1 cycle: done=1 → S_DONE; otherwise → S_COUNT.
- S_DONE: time_up=1. start=1 → S_SET for a restart; otherwise hold.
- running=1 in S_SET, S_COUNT, S_ONE, S_CHK1, S_TEN and S_CHK2.
- Divider:
  - CW-bit counter, cleared in S_WAIT, S_SET and S_DONE.
  - Increments in run states when pause=0; holds when pause=1.
  - Wraps at CLKS_PER_SEC-1; tick = (count == CLKS_PER_SEC-1) & ~pause.
  - sec_tick = tick & (state == S_COUNT).
- The divider keeps running through S_ONE to S_CHK2. That path is ≤ 4 cycles, below CLKS_PER_SEC, so every tick lands in S_COUNT and the second period is exact.
- start while running is ignored. pause outside run states has no effect.
- done and changeTen are consulted only in S_CHK2 and S_CHK1 respectively.

## Timing

- Reset, asynchronous:
  - state=S_WAIT, divider=0.
  - Outputs: ld_wait=1; ld_set, ld_one, ld_ten, sec_tick, running and time_up all 0.
- Reset asserted mid-round returns to S_WAIT immediately. The datapath is re-preset by ld_wait on the next clock.
- start sampled in S_WAIT gives ld_set high on the following cycle. The first sec_tick comes CLKS_PER_SEC cycles after S_COUNT is entered.
- Per second:
  - ld_one pulses exactly 1 cycle after sec_tick.
  - When a ten decrement is needed, ld_ten pulses 2 cycles after ld_one.
- Full round of 20 s:
  - 21 ld_one pulses (the 21st sees 00 and produces changeTen).
  - 3 ld_ten pulses: 20→19, 10→09, and 00→done.
  - time_up asserts 2 cycles after the final ld_ten, about 21·CLKS_PER_SEC cycles after S_SET.
- pause=1 on the tick cycle suppresses that tick. The divider resumes from CLKS_PER_SEC-1 when pause drops, so ticking resumes 1 cycle later.
- ld_set, ld_one and ld_ten are never asserted together and are each exactly one cycle wide.

## Test plan

All scenarios use CLKS_PER_SEC=8 with the real timer datapath attached.

1. Reset for 3 cycles, then release with start=0 → ld_wait=1, running=0, time_up=0, and the datapath reads 20 indefinitely.
2. Pulse start → ld_set on the next cycle; sec_tick every 8 cycles; displayed digits run 20, 19, 18 … 00; ld_ten is seen 2 cycles after the 1st, 11th and 21st ld_one.
3. Run the round to completion → time_up=1, done=1, counts held at 00, no further ld_* pulses; start then gives ld_set and the display returns to 20.
4. Hold pause high for 30 cycles at display 15 → no sec_tick and digits stay at 15; after release, ticking resumes at 8-cycle spacing with no lost or extra second.
5. Assert reset asynchronously mid-round at display 07 → outputs take their reset values before the next clk edge; the display returns to 20 one cycle after release.
6. Pulse start repeatedly while running → no ld_set and no disturbance to the tick spacing.
